// File: rtl/key_pulse_gen.sv
// Debounces an active-low pushbutton into a held level plus single-cycle pressed/released pulses.
// Define KEY_AUTOREPEAT_EN to build the auto-repeat of the pressed pulse while the key stays down.
module key_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed,
  output logic held,
  output logic released
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW    = (MAX_C > 2) ? $clog2(MAX_C) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // IDLE: up | PRESS_WAIT: debouncing a press | DOWN: accepted down | RELEASE_WAIT: debouncing a release
  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_DOWN,
    S_RELEASE_WAIT
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pressed;
  logic          r_held;
  logic          r_released;

  logic          w_key_s;
  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_pressed_nxt;
  logic          w_released_nxt;
  logic          w_held_nxt;

  assign w_key_s = r_sync2;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  // r_rep_phase: 0 while waiting for the first repeat, 1 for the periodic ones
  logic          r_rep_phase;
  logic          w_rep_phase_nxt;
  logic [CW-1:0] w_rep_last;

  assign w_rep_last = r_rep_phase ? RP_LAST : RD_LAST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rep_phase <= 1'b0;
    else     r_rep_phase <= w_rep_phase_nxt;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ~key_n;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pressed_nxt  = 1'b0;
    w_released_nxt = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    w_rep_phase_nxt = r_rep_phase;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_key_s) begin
          w_state_nxt = S_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!w_key_s) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt   = S_DOWN;
          w_cnt_nxt     = '0;
          w_pressed_nxt = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
          w_rep_phase_nxt = 1'b0;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DOWN: begin
        if (!w_key_s) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (r_cnt == w_rep_last) begin
          w_cnt_nxt       = '0;
          w_pressed_nxt   = 1'b1;
          w_rep_phase_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
      S_RELEASE_WAIT: begin
        // a bounce back to down restarts the repeat interval but never re-pulses pressed
        if (w_key_s) begin
          w_state_nxt = S_DOWN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt    = S_IDLE;
          w_cnt_nxt      = '0;
          w_released_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_held_nxt = (w_state_nxt == S_DOWN) || (w_state_nxt == S_RELEASE_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pressed  <= 1'b0;
      r_held     <= 1'b0;
      r_released <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pressed  <= w_pressed_nxt;
      r_held     <= w_held_nxt;
      r_released <= w_released_nxt;
    end
  end

  assign pressed  = r_pressed;
  assign held     = r_held;
  assign released = r_released;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Randomised and directed bench for key_pulse_gen with a run-length reference model of the debouncer.
module tb_key_pulse_gen;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_n = 1'b1;
  logic pressed, held, released;

  int n_err = 0;
  int n_chk = 0;

  key_pulse_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_n   (key_n),
    .pressed (pressed),
    .held    (held),
    .released(released)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: the key level seen by the debouncer is the raw level two samples late;
  // the accepted level flips once DB+1 consecutive samples disagree with it.
  logic smp[2];
  logic m_level = 1'b0;
  int   run = 0;
  int   rc = 0;
  int   interval = RD;
  logic m_pressed = 1'b0;
  logic m_released = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic ks;
    if (rst) begin
      smp[0] = 1'b0; smp[1] = 1'b0;
      m_level = 1'b0; run = 0; rc = 0; interval = RD;
      m_pressed = 1'b0; m_released = 1'b0;
    end else begin
      ks = smp[1];
      smp[1] = smp[0];
      smp[0] = !key_n;
      m_pressed = 1'b0;
      m_released = 1'b0;
      if (ks != m_level) begin
        run++;
        if (m_level) rc = -1;
        if (run == DB + 1) begin
          m_level = ks;
          run = 0;
          if (ks) begin
            m_pressed = 1'b1;
            rc = 0;
            interval = RD;
          end else begin
            m_released = 1'b1;
          end
        end
      end else begin
        run = 0;
        if (AR && m_level) begin
          if (rc < 0) rc = 0;
          else begin
            rc++;
            if (rc == interval) begin
              m_pressed = 1'b1;
              rc = 0;
              interval = RP;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_pressed", pressed, m_pressed);
    chk("model_held", held, m_level);
    chk("model_released", released, m_released);
    chk("no_press_and_release", pressed & released, 1'b0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cnt;
    ticks(3);
    chk("reset_pressed", pressed, 1'b0);
    chk("reset_held", held, 1'b0);
    chk("reset_released", released, 1'b0);
    rst = 1'b0;
    ticks(3);

    // clean press: key sampled low from edge 0, pressed only in cycle 6
    key_n = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      tick();
      chk("press_pulse", pressed, (k == 6));
      chk("press_held", held, (k >= 6));
    end
    // hold 30 more cycles: repeats at +10,+13,...,+28 only with auto-repeat
    cnt = 0;
    for (int j = 1; j <= 30; j++) begin
      tick();
      if (pressed) cnt++;
    end
    n_chk++;
    if (cnt != (AR ? 7 : 0)) begin
      n_err++;
      $display("FAIL repeat_count: got %0d expected %0d", cnt, AR ? 7 : 0);
    end

    // release glitch of two cycles
    key_n = 1'b1;
    ticks(2);
    key_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("glitch_held", held, 1'b1);
      chk("glitch_released", released, 1'b0);
    end

    // clean release
    key_n = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      tick();
      chk("release_pulse", released, (k == 6));
      chk("release_held", held, (k < 6));
    end
    ticks(3);

    // bounce: low 3, high 1, then low; pulse 6 cycles after final fall
    key_n = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); chk("bounce_early", pressed, 1'b0); end
    key_n = 1'b1;
    tick();
    chk("bounce_early", pressed, 1'b0);
    key_n = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      tick();
      chk("bounce_pulse", pressed, (k == 6));
    end
    key_n = 1'b1;
    ticks(12);

    // reset during PRESS_WAIT with key still held
    key_n = 1'b0;
    ticks(4);
    rst = 1'b1;
    #1;
    chk("rst_pw_pressed", pressed, 1'b0);
    chk("rst_pw_held", held, 1'b0);
    chk("rst_pw_released", released, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      tick();
      chk("rst_repress", pressed, (k == 6));
    end
    // reset while DOWN clears held immediately
    rst = 1'b1;
    #1;
    chk("rst_down_held", held, 1'b0);
    tick();
    rst = 1'b0;
    ticks(9);
    key_n = 1'b1;
    ticks(10);

    // randomised segments
    for (int s = 0; s < 300; s++) begin
      int len;
      key_n = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 12);
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        #1;
        chk("rand_rst_pressed", pressed, 1'b0);
        chk("rand_rst_held", held, 1'b0);
        chk("rand_rst_released", released, 1'b0);
        tick();
        rst = 1'b0;
      end
      ticks(len);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/key_pulse_gen.md
KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable clk cycles (20 ms at 50 MHz) required to accept a level change; legal range 2..2^24-1.
REQ-002 Parameter REPEAT_DELAY, default 25000000, clk cycles a key is held before the first auto-repeat pulse; used only with KEY_AUTOREPEAT_EN.
REQ-003 Parameter REPEAT_PERIOD, default 10000000, clk cycles between later auto-repeat pulses; used only with KEY_AUTOREPEAT_EN.
REQ-004 clk  input  1  system clock, 50 MHz board clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 key_n  input  1  raw DE10 pushbutton, active-low, asynchronous to clk, bouncing.
REQ-007 pressed  output  1  single-cycle pulse per accepted press (and per repeat); drives an event counter clock/enable.
REQ-008 held  output  1  debounced key level, 1 while the key is accepted as down.
REQ-009 released  output  1  single-cycle pulse per accepted release.

Function
REQ-010 key_n SHALL pass through a 2-flop synchronizer; the second stage (key_s, active-high after inversion) is the only value the FSM samples.
REQ-011 FSM states SHALL be IDLE, PRESS_WAIT, DOWN, RELEASE_WAIT; encoding is free.
REQ-012 IDLE: key_s=1 -> PRESS_WAIT with stable counter cleared to 0; else stay.
REQ-013 PRESS_WAIT: key_s=0 -> IDLE, counter cleared (bounce rejected); key_s=1 -> counter+1; counter reaching DEBOUNCE_CYCLES-1 while key_s=1 -> DOWN.
REQ-014 pressed SHALL be 1 for exactly the one cycle after the PRESS_WAIT->DOWN transition, i.e. the first cycle in DOWN.
REQ-015 DOWN: key_s=0 -> RELEASE_WAIT, counter cleared; else stay (auto-repeat per REQ-024).
REQ-016 RELEASE_WAIT: key_s=1 -> DOWN, counter cleared, no new pressed pulse; key_s=0 -> counter+1; counter reaching DEBOUNCE_CYCLES-1 -> IDLE, released pulsed in the first IDLE cycle.
REQ-017 held SHALL be 1 in DOWN and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
REQ-018 Latency: stable key_n low from cycle 0 SHALL yield pressed high in cycle 2+DEBOUNCE_CYCLES (±0); same latency for released after stable high.
REQ-019 Counter width SHALL be clog2 of the largest of DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD; it SHALL never wrap (saturates by state change).
REQ-020 pressed and released SHALL never be high in the same cycle; at most one pressed per accepted press without KEY_AUTOREPEAT_EN.
REQ-021 All outputs SHALL be registered (no combinational path from key_n).

Reset
REQ-022 rst high SHALL immediately force state IDLE, counter 0, synchronizer flops 0 (released), pressed=0, held=0, released=0, independent of clk.
REQ-023 rst asserted mid-debounce or in DOWN SHALL produce no pressed/released pulse on deassertion; a key still held at deassertion SHALL be debounced afresh and generate one pressed after 2+DEBOUNCE_CYCLES cycles.

Configuration
REQ-024 With KEY_AUTOREPEAT_EN defined: in DOWN, after REPEAT_DELAY cycles held, pressed SHALL pulse once, then every REPEAT_PERIOD cycles while key_s stays 1; entering RELEASE_WAIT halts the repeat timer, returning to DOWN from RELEASE_WAIT resumes it from 0 of the current interval.
REQ-025 Without KEY_AUTOREPEAT_EN: no repeat logic synthesized, REPEAT_DELAY/REPEAT_PERIOD ignored, one pressed per press regardless of hold time.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-026 Clean press: key_n 1->0 at cycle 0, held low -> pressed=1 only in cycle 6, held=1 from cycle 6.
REQ-027 Bounce: key_n low 3 cycles, high 1, low stable -> single pressed pulse 6 cycles after final falling edge, none earlier.
REQ-028 Release glitch: in DOWN, key_n high 2 cycles then low -> held stays 1, no released, no extra pressed.
REQ-029 Clean release: key_n 0->1 stable -> released=1 in exactly one cycle, 6 cycles later; held=0 same cycle.
REQ-030 Reset mid-operation: rst pulsed during PRESS_WAIT with key held -> all outputs 0 immediately, one pressed 6 cycles after rst falls.
REQ-031 Auto-repeat (macro defined): hold 30 cycles after initial pressed -> repeat pulses at +10, +13, +16, ..., +28; none with macro undefined.
